// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter with hold-limit timeout.
// The arbiter top, the rotating-priority picker and the bench all import this package.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_DEFAULT        = 8;
    localparam int MAX_HOLD_DEFAULT = 4;

    // Slot that follows idx in an n-entry ring; the pointer moves here after a release.
    function automatic int next_slot(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first set req bit, scanning from ptr
// upward and wrapping past N-1 back to 0. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] index
);

    always_comb begin
        logic          found;
        int            slot;
        logic [PW-1:0] slot_idx;
        pick     = '0;
        index    = '0;
        found    = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int i = 0; i < N; i++) begin
            slot = int'(ptr) + i;
            if (slot >= N) begin
                slot = slot - N;
            end
            slot_idx = PW'(slot);
            if (!found && req[slot_idx]) begin
                found          = 1'b1;
                pick[slot_idx] = 1'b1;
                index          = slot_idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_hold_timeout.sv
// Round-robin arbiter that holds a grant until done, the owner drops its
// request, or the hold limit expires; the last case raises a one-cycle timeout.
//
//   state | meaning
//   IDLE  | no owner; next ena strobe with any req picks an owner from ptr
//   GRANT | one requester owns the resource; hold_cnt counts strobes held
module rr_arbiter_hold_timeout
    import arb_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("rr_arbiter_hold_timeout: N must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_hold_timeout: MAX_HOLD must be in 1..255");
    end

    arb_state_t    state_q,   state_d;
    logic [PW-1:0] ptr_q,     ptr_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic [N-1:0]  gnt_q,     gnt_d;
    logic [PW-1:0] id_q,      id_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  pick;
    logic [PW-1:0] pick_idx;
    logic          owner_req;
    logic          hold_hit;
    logic          release_now;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .index (pick_idx)
    );

    assign owner_req   = req[id_q];
    assign hold_hit    = (hold_q == HW'(MAX_HOLD - 1));
    assign release_now = done || !owner_req || hold_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_d = GRANT;
                        gnt_d   = pick;
                        id_d    = pick_idx;
                        hold_d  = '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        id_d      = '0;
                        ptr_d     = PW'(next_slot(int'(id_q), N));
                        // Only a pure hold-limit expiry counts as a timeout.
                        timeout_d = hold_hit && !done && owner_req;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_hold_timeout.sv
// Bench for rr_arbiter_hold_timeout (N=8, MAX_HOLD=4): directed scenarios with
// literal expectations, then randomized traffic, all against an owner/ring model.
module tb_rr_arbiter_hold_timeout;

    localparam int N  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         done = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [2:0]   gnt_id;
    logic         timeout;

    rr_arbiter_hold_timeout #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    // Model: who owns the resource (-1 = nobody), how many strobes it has
    // already held, where the next scan starts, and whether a timeout fired.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_to    = 0;
        end else begin
            m_to = 0;
            if (ena) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (req[c]) begin
                            m_owner = c;
                            m_held  = 0;
                            break;
                        end
                    end
                end else begin
                    bit limit;
                    limit = (m_held + 1 >= MH);
                    if (done || !req[m_owner] || limit) begin
                        m_to    = limit && !done && req[m_owner];
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                    end else begin
                        m_held = m_held + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            int exp_gnt;
            exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
            chk("model_gnt", int'(gnt), exp_gnt);
            chk("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
            chk("model_gnt_id", int'(gnt_id), (m_owner < 0) ? 0 : m_owner);
            chk("model_timeout", int'(timeout), int'(m_to));
            chk("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic d, input logic e, input logic rs);
        req  = r;
        done = d;
        ena  = e;
        rst  = rs;
        @(negedge clk);
    endtask

    initial begin
        drive(8'h00, 0, 1, 1);
        checking = 1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_id", int'(gnt_id), 0);
        chk("rst_timeout", int'(timeout), 0);

        // Two requesters, hold limit expires on each in turn.
        drive(8'h05, 0, 1, 0);
        chk("hold_first_gnt", int'(gnt), 8'h01);
        repeat (3) drive(8'h05, 0, 1, 0);
        chk("hold_fourth_gnt", int'(gnt), 8'h01);
        chk("hold_fourth_to", int'(timeout), 0);
        drive(8'h05, 0, 1, 0);
        chk("hold_release_gnt", int'(gnt), 0);
        chk("hold_release_to", int'(timeout), 1);
        drive(8'h05, 0, 1, 0);
        chk("hold_second_gnt", int'(gnt), 8'h04);
        chk("hold_second_id", int'(gnt_id), 2);
        chk("hold_second_to", int'(timeout), 0);
        repeat (4) drive(8'h05, 0, 1, 0);
        chk("hold_second_rel_to", int'(timeout), 1);

        // Owner 2 released, ptr=3: wrap scan picks 7 then 0.
        drive(8'h81, 0, 1, 0);
        chk("wrap_gnt7", int'(gnt), 8'h80);
        chk("wrap_id7", int'(gnt_id), 7);
        drive(8'h81, 1, 1, 0);
        chk("wrap_done_gnt", int'(gnt), 0);
        chk("wrap_done_to", int'(timeout), 0);
        drive(8'h81, 0, 1, 0);
        chk("wrap_gnt0", int'(gnt), 8'h01);

        // done on the same strobe as the hold limit: no timeout.
        repeat (3) drive(8'h81, 0, 1, 0);
        drive(8'h81, 1, 1, 0);
        chk("done_limit_gnt", int'(gnt), 0);
        chk("done_limit_to", int'(timeout), 0);

        // Owner drops its request after two strobes; ptr moves past it.
        drive(8'h06, 0, 1, 0);
        chk("drop_gnt", int'(gnt), 8'h02);
        repeat (2) drive(8'h06, 0, 1, 0);
        drive(8'h04, 0, 1, 0);
        chk("drop_rel_gnt", int'(gnt), 0);
        chk("drop_rel_to", int'(timeout), 0);
        drive(8'h05, 0, 1, 0);
        chk("drop_next_gnt", int'(gnt), 8'h04);

        // Reset mid-grant drops owner 5 and restarts the ring at 0.
        drive(8'h00, 0, 1, 1);
        drive(8'h20, 0, 1, 0);
        chk("rst_mid_gnt5", int'(gnt), 8'h20);
        drive(8'h20, 0, 1, 0);
        drive(8'h20, 0, 1, 1);
        chk("rst_mid_drop", int'(gnt), 0);
        chk("rst_mid_to", int'(timeout), 0);
        drive(8'h28, 0, 1, 0);
        chk("rst_mid_regrant", int'(gnt), 8'h08);

        // Sparse ena: nothing moves between strobes.
        drive(8'h00, 0, 1, 0);
        drive(8'h30, 0, 0, 0);
        chk("ena_low_idle", int'(gnt), 0);
        drive(8'h30, 0, 1, 0);
        chk("ena_strobe_gnt", int'(gnt), 8'h10);
        repeat (2) drive(8'h30, 0, 0, 0);
        chk("ena_hold_gnt", int'(gnt), 8'h10);
        for (int i = 0; i < 36; i++) begin
            drive(8'h30, 0, (i % 3 == 2), 0);
        end

        // Randomized traffic: first every-3rd-clk ena, then random ena.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            logic         e;
            r = req;
            if ($urandom_range(3) == 0) begin
                r = N'($urandom) & N'($urandom);
            end
            e = (i < 600) ? (i % 3 == 0) : ($urandom_range(9) < 7);
            drive(r, ($urandom_range(7) == 0), e, ($urandom_range(199) == 0));
        end

        drive(8'h00, 0, 1, 0);
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_hold_timeout.md
RR_ARBITER_HOLD_TIMEOUT -- requirements
Module: rr_arbiter_hold_timeout

Interface
REQ-001 Parameter N, default 8: number of requesters, 2..8.
REQ-002 Parameter MAX_HOLD, default 4: maximum grant length in ena strobes, 1..255.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ena  input  1  advance strobe; all state updates qualified by ena=1.
REQ-006 req  input  N  request vector, one bit per requester, level-sensitive.
REQ-007 done  input  1  current owner releases the resource; sampled only with ena=1 in GRANT.
REQ-008 gnt  output  N  one-hot grant, registered; all zeros when no owner.
REQ-009 gnt_valid  output  1  high while any gnt bit is set.
REQ-010 gnt_id  output  $clog2(N)  binary index of owner; 0 when gnt_valid=0.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT, and a rotating pointer ptr (0..N-1).
REQ-013 With ena=0, state, ptr, hold counter and gnt SHALL hold; timeout SHALL be 0.
REQ-014 In IDLE with ena=1 and req!=0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1; then assert that gnt bit, load gnt_id, clear hold_cnt and enter GRANT on the same edge.
REQ-015 In IDLE with ena=1 and req=0, state, ptr and gnt SHALL stay unchanged.
REQ-016 In GRANT with ena=1, release SHALL occur if done=1, req[owner]=0, or hold_cnt=MAX_HOLD-1.
REQ-017 On release: gnt=0, gnt_valid=0, gnt_id=0, ptr=owner+1 (wrapping N-1 -> 0), enter IDLE; the next grant needs a further ena strobe (one-strobe gap minimum).
REQ-018 timeout SHALL pulse on the release edge only when the hold limit alone caused release; if done=1 or req[owner]=0 on the same strobe, timeout SHALL stay 0.
REQ-019 In GRANT with ena=1 and no release, hold_cnt SHALL increment by 1; its width is $clog2(MAX_HOLD+1) and it never wraps.
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one ena strobe.
REQ-021 Changes of req bits other than the owner's SHALL not affect an active grant.
REQ-022 gnt SHALL never have more than one bit set; gnt_valid SHALL equal |gnt.
REQ-023 Grant latency SHALL be 1 clk after the ena edge that samples req.

Reset
REQ-024 On rst=1 at a clk edge: state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, regardless of ena.
REQ-025 Reset during GRANT SHALL drop the grant on that edge with no timeout pulse.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default N/MAX_HOLD constants.
REQ-027 Rotating-priority selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot pick and index); the FSM, counter and pointer stay in the top module.
REQ-028 Board integration SHALL drive ena from the existing strobe generator.

Verification (N=8, MAX_HOLD=4, ena=1 every clk unless stated)
REQ-029 Reset, then req=8'b0000_0101 held -> gnt 0x01 for 4 clks with timeout at release, idle 1 clk, then gnt 0x04 for 4 clks.
REQ-030 Owner 2 granted, ptr=3, req=8'b1000_0001 -> next grant is bit 7 (0x80), then bit 0 (wrap).
REQ-031 done=1 and hold_cnt=3 on the same strobe -> release with timeout=0.
REQ-032 Owner drops req after 2 strobes -> release on that strobe, timeout=0, ptr=owner+1.
REQ-033 ena pulsing every 3rd clk -> all transitions only on ena clks; gnt unchanged between strobes.
REQ-034 rst asserted mid-GRANT with owner 5 -> gnt=0 next edge, ptr=0, first grant after reset goes to lowest set req bit.
